// File: rtl/mul_seq_pkg.sv
// Shared types and widths for the multiplier operand sequencer.
package mul_seq_pkg;

  localparam int OP1_W   = 32;
  localparam int OP2_W   = 64;
  localparam int RES_W   = 64;
  localparam int ENTRY_W = 1 + OP1_W + OP2_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic             muordi;
    logic [OP1_W-1:0] opera1;
    logic [OP2_W-1:0] opera2;
  } seq_entry_t;

  function automatic seq_entry_t pack_entry(input logic md, input logic [OP1_W-1:0] a,
                                            input logic [OP2_W-1:0] b);
    seq_entry_t e;
    e.muordi = md;
    e.opera1 = a;
    e.opera2 = b;
    return e;
  endfunction

endpackage

// File: rtl/mul_seq_fifo.sv
// Request FIFO: single clock, async reset, count-based full/empty flags.
module mul_seq_fifo #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 97
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] wdata,
  output logic [ENTRY_W-1:0] rdata,
  output logic               full,
  output logic               empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               do_push_s;
  logic               do_pop_s;

  // A full FIFO refuses the push even when a pop happens in the same cycle.
  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == CNT_W'(0));
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign rdata     = mem_r[rd_ptr_r];

  // Storage array write port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {ENTRY_W{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      if (do_push_s && !do_pop_s) begin
        count_r <= count_r + CNT_W'(1);
      end else if (do_pop_s && !do_push_s) begin
        count_r <= count_r - CNT_W'(1);
      end else begin
        count_r <= count_r;
      end
    end
  end

endmodule

// File: rtl/mul_operand_sequencer.sv
// Issue stage for the sequential multiplier: queues requests, pulses start,
// waits for a rising valid edge and returns the captured result.
module mul_operand_sequencer
  import mul_seq_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 128
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP1_W-1:0] in_opera1,
  input  logic [OP2_W-1:0] in_opera2,
  input  logic             in_muordi,
  output logic [OP1_W-1:0] opera1,
  output logic [OP2_W-1:0] opera2,
  output logic             muordi,
  output logic             start,
  input  logic             valid,
  input  logic [RES_W-1:0] result,
  output logic             out_valid,
  output logic [RES_W-1:0] out_result,
  output logic             busy,
  output logic             timeout_err
);

  localparam int SC_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  seq_state_e         state_r;
  logic [SC_W-1:0]    start_cnt_r;
  logic [TO_W-1:0]    tmo_cnt_r;
  logic               valid_q_r;
  logic               timed_out_r;
  logic               done_s;
  logic               pop_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [ENTRY_W-1:0] head_raw_s;
  seq_entry_t         head_s;

  mul_seq_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (in_valid),
    .pop   (pop_s),
    .wdata (pack_entry(in_muordi, in_opera1, in_opera2)),
    .rdata (head_raw_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign head_s   = seq_entry_t'(head_raw_s);
  assign in_ready = ~fifo_full_s;
  assign done_s   = valid & ~valid_q_r;
  assign pop_s    = (state_r == ST_DONE);
  assign busy     = (state_r != ST_IDLE) | ~fifo_empty_s;

  // Sequencer FSM with its counters, valid edge detect and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      start_cnt_r <= SC_W'(0);
      tmo_cnt_r   <= TO_W'(0);
      valid_q_r   <= 1'b0;
      timed_out_r <= 1'b0;
      opera1      <= {OP1_W{1'b0}};
      opera2      <= {OP2_W{1'b0}};
      muordi      <= 1'b0;
      start       <= 1'b0;
      out_valid   <= 1'b0;
      out_result  <= {RES_W{1'b0}};
      timeout_err <= 1'b0;
    end else begin
      valid_q_r <= valid;
      out_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!fifo_empty_s) begin
            opera1      <= head_s.opera1;
            opera2      <= head_s.opera2;
            muordi      <= head_s.muordi;
            start       <= 1'b1;
            start_cnt_r <= SC_W'(START_CYCLES - 1);
            state_r     <= ST_LOAD;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (start_cnt_r == SC_W'(0)) begin
            start     <= 1'b0;
            tmo_cnt_r <= TO_W'(TIMEOUT - 1);
            state_r   <= ST_RUN;
          end else begin
            start_cnt_r <= start_cnt_r - SC_W'(1);
          end
        end
        ST_RUN: begin
          // A genuine completion beats an expiring timeout in the same cycle.
          if (done_s) begin
            out_result  <= result;
            timed_out_r <= 1'b0;
            state_r     <= ST_DONE;
          end else if (tmo_cnt_r == TO_W'(0)) begin
            timeout_err <= 1'b1;
            timed_out_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r - TO_W'(1);
          end
        end
        ST_DONE: begin
          out_valid <= ~timed_out_r;
          state_r   <= ST_IDLE;
        end
        default: begin
          start   <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Randomised scoreboard bench for mul_operand_sequencer with a behavioural
// multiplier (configurable latency, stuck-high and pre-high valid modes).
module tb_mul_operand_sequencer;

  localparam int START_CYCLES = 2;
  localparam int TIMEOUT      = 128;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_opera1 = 32'd0;
  logic [63:0] in_opera2 = 64'd0;
  logic        in_muordi = 1'b0;
  logic [31:0] opera1;
  logic [63:0] opera2;
  logic        muordi;
  logic        start;
  logic        valid = 1'b0;
  logic [63:0] result = 64'd0;
  logic        out_valid;
  logic [63:0] out_result;
  logic        busy;
  logic        timeout_err;

  typedef struct {
    logic [63:0] res;
    logic [31:0] a;
    logic [63:0] b;
    logic        md;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ov_cnt = 0;
  int   mode = 0;   // 0 normal, 1 valid pre-high, 2 valid stuck high
  int   lat = 8;
  int   cyc = 0;
  int   fall_cyc = 0;

  mul_operand_sequencer #(
    .DEPTH(4), .START_CYCLES(START_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opera1(in_opera1), .in_opera2(in_opera2), .in_muordi(in_muordi),
    .opera1(opera1), .opera2(opera2), .muordi(muordi), .start(start),
    .valid(valid), .result(result), .out_valid(out_valid),
    .out_result(out_result), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [63:0] b);
    longint sa;
    longint sb64;
    sa   = longint'($signed(a));
    sb64 = $signed(b);
    return 64'(sa * sb64);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_opera1", 64'(opera1), 64'd0);
    check("rst_opera2", opera2, 64'd0);
    check("rst_muordi", 64'(muordi), 64'd0);
    check("rst_start", 64'(start), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", out_result, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_timeout_err", 64'(timeout_err), 64'd0);
  endtask

  task automatic do_push(input logic [31:0] a, input logic [63:0] b, input logic md,
                         input bit expect_res);
    bit acc;
    exp_t e;
    acc = 1'b0;
    @(negedge clock);
    in_valid = 1'b1; in_opera1 = a; in_opera2 = b; in_muordi = md;
    for (int k = 0; k < 600 && !acc; k++) begin
      if (in_ready) begin
        if (expect_res) begin
          e.res = ref_mul(a, b); e.a = a; e.b = b; e.md = md;
          sb.push_back(e);
        end
        acc = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
      end else begin
        @(negedge clock);
      end
    end
    if (!acc) begin
      in_valid = 1'b0;
      check("push_accept_timeout", 64'd0, 64'd1);
    end
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge clock);
      if (sb.size() == 0 && !busy) ok = 1'b1;
    end
    if (!ok) check("drain_timeout", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clock);
  endtask

  // Behavioural multiplier: captures operands when start falls, answers after lat cycles.
  logic [31:0] cap1;
  logic [63:0] cap2;
  int slen = 0;
  int run_cnt = -1;
  initial begin
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (reset) begin
        slen = 0; run_cnt = -1;
        if (mode != 2) valid = 1'b0;
      end else begin
        if (start) begin
          slen++;
          if (mode == 0) valid = 1'b0;
        end else if (slen > 0) begin
          check("start_len", 64'(slen), 64'(START_CYCLES));
          slen = 0; cap1 = opera1; cap2 = opera2; fall_cyc = cyc;
          if (mode != 2) run_cnt = lat;
        end else if (run_cnt > 0) begin
          check("run_opera1_stable", 64'(opera1), 64'(cap1));
          check("run_opera2_stable", opera2, cap2);
          run_cnt--;
          if (mode == 1 && run_cnt == 4) valid = 1'b0;
          if (run_cnt == 0) begin
            result = ref_mul(cap1, cap2);
            valid = 1'b1;
            run_cnt = -1;
          end
        end
        if (mode == 2) valid = 1'b1;
      end
    end
  end

  // Monitor: every result strobe must match the oldest outstanding request.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && out_valid) begin
        ov_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("out_result", out_result, e.res);
          check("out_opera1", 64'(opera1), 64'(e.a));
          check("out_opera2", opera2, e.b);
          check("out_muordi", 64'(muordi), 64'(e.md));
        end
      end
    end
  end

  initial begin
    int ov0;
    bit acc;
    exp_t e;
    repeat (3) @(negedge clock);
    check_reset_vals();
    reset = 1'b0;
    @(negedge clock);
    check_reset_vals();

    // Single request
    ov0 = ov_cnt;
    do_push(32'd2, 64'd32, 1'b0, 1'b1);
    wait_drain();
    check("single_ov_count", 64'(ov_cnt - ov0), 64'd1);
    check("single_result", out_result, 64'd64);

    // Sign combinations back-to-back
    do_push(-32'sd2, 64'd32, 1'b0, 1'b1);
    do_push(32'd2, -64'sd32, 1'b0, 1'b1);
    do_push(-32'sd2, -64'sd32, 1'b0, 1'b1);
    wait_drain();
    check("b2b_last_result", out_result, 64'd64);

    // Random requests with random gaps
    ov0 = ov_cnt;
    for (int i = 0; i < 16; i++) begin
      do_push($urandom, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    wait_drain();
    check("random_ov_count", 64'(ov_cnt - ov0), 64'd16);

    // Stalled multiplier: fill the FIFO, fifth push waits for the first DONE
    lat = 40;
    for (int i = 0; i < 4; i++) do_push($urandom, {$urandom, $urandom}, 1'b0, 1'b1);
    check("full_in_ready", 64'(in_ready), 64'd0);
    @(negedge clock);
    in_valid = 1'b1; in_opera1 = 32'd7; in_opera2 = 64'd9; in_muordi = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 400 && !acc; k++) begin
      if (in_ready) begin
        check("ready_with_first_done", 64'(out_valid), 64'd1);
        e.res = 64'd63; e.a = 32'd7; e.b = 64'd9; e.md = 1'b1;
        sb.push_back(e);
        acc = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
      end else begin
        @(negedge clock);
      end
    end
    if (!acc) begin
      in_valid = 1'b0;
      check("fifth_push_timeout", 64'd0, 64'd1);
    end
    wait_drain();
    lat = 8;

    // valid already high before LOAD; only the later rise counts
    mode = 1; valid = 1'b1;
    repeat (3) @(negedge clock);
    ov0 = ov_cnt;
    do_push(32'd3, 64'd5, 1'b0, 1'b1);
    wait_drain();
    check("prehigh_ov_count", 64'(ov_cnt - ov0), 64'd1);
    check("prehigh_result", out_result, 64'd15);

    // valid stuck high: request times out after TIMEOUT cycles in RUN
    check("tmo_err_before", 64'(timeout_err), 64'd0);
    mode = 2;
    ov0 = ov_cnt;
    do_push(32'd4, 64'd4, 1'b0, 1'b0);
    acc = 1'b0;
    for (int k = 0; k < 400 && !acc; k++) begin
      @(posedge clock);
      #2;
      if (timeout_err) acc = 1'b1;
    end
    check("tmo_err_set", 64'(timeout_err), 64'd1);
    check("tmo_run_len", 64'(cyc - fall_cyc), 64'(TIMEOUT));
    wait_drain();
    check("tmo_no_out_valid", 64'(ov_cnt - ov0), 64'd0);
    check("tmo_result_kept", out_result, 64'd15);
    mode = 0;
    do_push(32'd6, 64'd7, 1'b0, 1'b1);
    wait_drain();
    check("after_tmo_result", out_result, 64'd42);
    check("tmo_err_sticky", 64'(timeout_err), 64'd1);

    // Reset in RUN with three requests queued
    lat = 40;
    for (int i = 0; i < 4; i++) do_push($urandom, {$urandom, $urandom}, 1'b1, 1'b1);
    repeat (10) @(posedge clock);
    #3 reset = 1'b1;
    sb.delete();
    #1 check_reset_vals();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    lat = 8;
    ov0 = ov_cnt;
    repeat (100) @(negedge clock);
    check("post_reset_no_out_valid", 64'(ov_cnt - ov0), 64'd0);
    check("post_reset_busy", 64'(busy), 64'd0);
    check("post_reset_start", 64'(start), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_operand_sequencer.md
# mul_operand_sequencer

Upstream issue stage for the sequential `multiplier`. It buffers operand requests from the datapath in a small FIFO and drives one request at a time into the multiplier. For each request it generates the multi-cycle `start` pulse, holds the operands stable, and waits for the multiplier's `valid` rising edge. It then returns the 64-bit result, tagged, to the requester, and flags an error on timeout.

## Interface
- `DEPTH`, 4: request FIFO entries; power of two, at least 2.
- `START_CYCLES`, 2: cycles `start` is held high per request; at least 1.
- `TIMEOUT`, 128: maximum cycles in RUN before the request is abandoned.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  FIFO not full.
- `in_opera1`  in  32  multiplicand, two's complement.
- `in_opera2`  in  64  multiplier operand, two's complement.
- `in_muordi`  in  1  op select, passed through (0 = multiply).
- `opera1`  out  32  to multiplier.
- `opera2`  out  64  to multiplier.
- `muordi`  out  1  to multiplier.
- `start`  out  1  to multiplier.
- `valid`  in  1  from multiplier, level.
- `result`  in  64  from multiplier.
- `out_valid`  out  1  one-cycle result strobe.
- `out_result`  out  64  captured result.
- `busy`  out  1  FSM not IDLE, or FIFO not empty.
- `timeout_err`  out  1  sticky; cleared only by reset.

## Operation
- Push happens when `in_valid & in_ready`. The entry is `{in_muordi, in_opera1, in_opera2}`.
- `in_ready = ~full`. A push is refused when full, even if a pop occurs in the same cycle.
- FSM states are IDLE, LOAD, RUN, DONE.
- IDLE to LOAD when the FIFO is not empty.
  - The head entry is copied to `opera1`/`opera2`/`muordi` registers on that edge.
  - The start counter loads `START_CYCLES-1`.
- LOAD:
  - `start=1` and the counter decrements.
  - When the counter reaches 0, go to RUN and load the timeout counter with `TIMEOUT-1`.
- RUN:
  - `start=0`.
  - `valid_q` is a registered copy of `valid`. `done = valid & ~valid_q`.
  - If `done` is true, capture `result` into `out_result` and go to DONE.
  - Otherwise, when the timeout counter reaches 0, set `timeout_err` and go to DONE. Do not assert `out_valid` in this case, and leave `out_result` unchanged.
  - `done` and timeout expiry in the same cycle: `done` wins.
- DONE:
  - `out_valid=1` for this single cycle, unless the request timed out.
  - Pop the FIFO head and return to IDLE.
- Operand outputs hold their values from the LOAD entry until the next LOAD, including through IDLE.
- `valid` held high while in IDLE or LOAD is ignored. Only a rising edge seen in RUN completes a request.
- No arithmetic is done here. Operand widths pass through unchanged and sign handling belongs to the multiplier.

## Timing
- Reset values: `in_ready=1`, `opera1=0`, `opera2=0`, `muordi=0`, `start=0`, `out_valid=0`, `out_result=0`, `busy=0`, `timeout_err=0`. The FSM resets to IDLE, the FIFO to empty and `valid_q` to 0.
- Request latency:
  - Push at edge N makes the FIFO non-empty after N.
  - LOAD is entered at edge N+1.
  - `start` is high during cycles N+1 through N+START_CYCLES.
  - RUN is entered at edge N+1+START_CYCLES.
- Result timing: if `valid` rises in the cycle before edge M, then `out_valid` is high for the cycle after edge M+1 and `out_result` is stable from edge M+1.
- Back-to-back requests: at least one IDLE cycle separates DONE from the next LOAD.
- Reset asserted mid-operation clears `start` immediately (asynchronously). Queued requests are discarded and no `out_valid` is produced.

## Structure
- Package `mul_seq_pkg` holds:
  - the state enum (IDLE, LOAD, RUN, DONE);
  - width constants `OP1_W=32`, `OP2_W=64`, `RES_W=64`;
  - `ENTRY_W = 1+OP1_W+OP2_W`.
- Sub-module `mul_seq_fifo`: a synchronous FIFO with async reset, a single clock, `full`/`empty` flags, and parameters `DEPTH`/`ENTRY_W`.
- The FSM, counters, `valid` edge detect and output registers live in `mul_operand_sequencer`.

## Test plan
- Use a behavioural multiplier model with an 8-cycle latency.
  - Stimulus: push (2, 32).
  - Required: `start` is high for exactly 2 cycles, and `out_valid` pulses once with `out_result=64`.
- Push (-2, 32), (2, -32) and (-2, -32) back-to-back. Required results in order: 0xFFFF_FFFF_FFFF_FFC0, 0xFFFF_FFFF_FFFF_FFC0, 64. The operands must stay stable throughout each RUN.
- Push 5 requests with the model stalled.
  - Required: `in_ready=0` after the 4th push, and the 5th push is not accepted until the first DONE.
- Hold `valid` high continuously with no rising edge.
  - Required: RUN exits after 128 cycles, `timeout_err=1`, no `out_valid`, and the next request still completes.
- Hold `valid` high before LOAD, then produce a proper fall and rise later. Required: exactly one `out_valid`, on the later rising edge.
- Assert `reset` in RUN with 3 entries queued.
  - Required: all outputs go to their reset values, `busy=0`, and no `out_valid` follows.
